// File: rtl/rvx10_pkg.sv
//------------------------------------------------------------------------------
// Module : rvx10_pkg
// Brief  : Shared op enum, opcode/funct constants and field-packing helpers.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package rvx10_pkg;

    typedef enum logic [4:0] {
        OP_ADD  = 5'd0,
        OP_SUB  = 5'd1,
        OP_AND  = 5'd2,
        OP_OR   = 5'd3,
        OP_SLT  = 5'd4,
        OP_ADDI = 5'd5,
        OP_ANDI = 5'd6,
        OP_ORI  = 5'd7,
        OP_SLTI = 5'd8,
        OP_LW   = 5'd9,
        OP_SW   = 5'd10,
        OP_BEQ  = 5'd11,
        OP_JAL  = 5'd12,
        OP_ANDN = 5'd13,
        OP_ORN  = 5'd14,
        OP_XNOR = 5'd15,
        OP_MIN  = 5'd16,
        OP_MAX  = 5'd17,
        OP_MINU = 5'd18,
        OP_MAXU = 5'd19,
        OP_ROL  = 5'd20,
        OP_ROR  = 5'd21,
        OP_ABS  = 5'd22
    } enc_op_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_ERR   = 2'd3
    } state_t;

    localparam logic [6:0] C_OPC_R      = 7'b0110011;
    localparam logic [6:0] C_OPC_IALU   = 7'b0010011;
    localparam logic [6:0] C_OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] C_OPC_STORE  = 7'b0100011;
    localparam logic [6:0] C_OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] C_OPC_JAL    = 7'b1101111;
    localparam logic [6:0] C_OPC_RVX10  = 7'b0001011;

    localparam logic [6:0] C_F7_BASE    = 7'b0000000;
    localparam logic [6:0] C_F7_SUB     = 7'b0100000;
    localparam logic [6:0] C_F7_LOGIC   = 7'b0000000;
    localparam logic [6:0] C_F7_MINMAX  = 7'b0000001;
    localparam logic [6:0] C_F7_ROT     = 7'b0000010;
    localparam logic [6:0] C_F7_ABS     = 7'b0000011;

    localparam logic [2:0] C_F3_ADD     = 3'b000;
    localparam logic [2:0] C_F3_SLT     = 3'b010;
    localparam logic [2:0] C_F3_OR      = 3'b110;
    localparam logic [2:0] C_F3_AND     = 3'b111;
    localparam logic [2:0] C_F3_WORD    = 3'b010;
    localparam logic [2:0] C_F3_BEQ     = 3'b000;

    localparam logic [2:0] C_F3_ANDN    = 3'b000;
    localparam logic [2:0] C_F3_ORN     = 3'b001;
    localparam logic [2:0] C_F3_XNOR    = 3'b010;
    localparam logic [2:0] C_F3_MIN     = 3'b000;
    localparam logic [2:0] C_F3_MAX     = 3'b001;
    localparam logic [2:0] C_F3_MINU    = 3'b010;
    localparam logic [2:0] C_F3_MAXU    = 3'b011;
    localparam logic [2:0] C_F3_ROL     = 3'b000;
    localparam logic [2:0] C_F3_ROR     = 3'b001;
    localparam logic [2:0] C_F3_ABS     = 3'b000;

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [6:0] opc);
        return {f7, rs2, rs1, f3, rd, opc};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] opc);
        return {imm, rs1, f3, rd, opc};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1);
        return {imm[11:5], rs2, rs1, C_F3_WORD, imm[4:0], C_OPC_STORE};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:1] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1);
        return {imm[12], imm[10:5], rs2, rs1, C_F3_BEQ, imm[4:1], imm[11], C_OPC_BRANCH};
    endfunction

    function automatic logic [31:0] enc_j(input logic [20:1] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, C_OPC_JAL};
    endfunction

endpackage

`default_nettype wire

// File: rtl/rvx10_encdec.sv
//------------------------------------------------------------------------------
// Module : rvx10_encdec
// Brief  : Combinational op/field/immediate to instruction word encoder with
//          illegal-op and immediate range detection.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module rvx10_encdec
    import rvx10_pkg::*;
(
    input  logic [4:0]  op,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] imm,
    output logic [31:0] word,
    output logic        illegal
);

    logic signed [31:0] w_imm_s;
    logic               w_i_ok;
    logic               w_b_ok;
    logic               w_j_ok;

    assign w_imm_s = $signed(imm);
    assign w_i_ok  = (w_imm_s >= -32'sd2048)    && (w_imm_s <= 32'sd2047);
    assign w_b_ok  = (w_imm_s >= -32'sd4096)    && (w_imm_s <= 32'sd4094)    && !imm[0];
    assign w_j_ok  = (w_imm_s >= -32'sd1048576) && (w_imm_s <= 32'sd1048574) && !imm[0];

    always_comb begin
        word    = 32'd0;
        illegal = 1'b0;
        case (op)
            OP_ADD:  word = enc_r(C_F7_BASE, rs2, rs1, C_F3_ADD, rd, C_OPC_R);
            OP_SUB:  word = enc_r(C_F7_SUB,  rs2, rs1, C_F3_ADD, rd, C_OPC_R);
            OP_AND:  word = enc_r(C_F7_BASE, rs2, rs1, C_F3_AND, rd, C_OPC_R);
            OP_OR:   word = enc_r(C_F7_BASE, rs2, rs1, C_F3_OR,  rd, C_OPC_R);
            OP_SLT:  word = enc_r(C_F7_BASE, rs2, rs1, C_F3_SLT, rd, C_OPC_R);
            OP_ADDI: begin
                word    = enc_i(imm[11:0], rs1, C_F3_ADD, rd, C_OPC_IALU);
                illegal = !w_i_ok;
            end
            OP_ANDI: begin
                word    = enc_i(imm[11:0], rs1, C_F3_AND, rd, C_OPC_IALU);
                illegal = !w_i_ok;
            end
            OP_ORI: begin
                word    = enc_i(imm[11:0], rs1, C_F3_OR, rd, C_OPC_IALU);
                illegal = !w_i_ok;
            end
            OP_SLTI: begin
                word    = enc_i(imm[11:0], rs1, C_F3_SLT, rd, C_OPC_IALU);
                illegal = !w_i_ok;
            end
            OP_LW: begin
                word    = enc_i(imm[11:0], rs1, C_F3_WORD, rd, C_OPC_LOAD);
                illegal = !w_i_ok;
            end
            OP_SW: begin
                word    = enc_s(imm[11:0], rs2, rs1);
                illegal = !w_i_ok;
            end
            OP_BEQ: begin
                word    = enc_b(imm[12:1], rs2, rs1);
                illegal = !w_b_ok;
            end
            OP_JAL: begin
                word    = enc_j(imm[20:1], rd);
                illegal = !w_j_ok;
            end
            OP_ANDN: word = enc_r(C_F7_LOGIC,  rs2, rs1, C_F3_ANDN, rd, C_OPC_RVX10);
            OP_ORN:  word = enc_r(C_F7_LOGIC,  rs2, rs1, C_F3_ORN,  rd, C_OPC_RVX10);
            OP_XNOR: word = enc_r(C_F7_LOGIC,  rs2, rs1, C_F3_XNOR, rd, C_OPC_RVX10);
            OP_MIN:  word = enc_r(C_F7_MINMAX, rs2, rs1, C_F3_MIN,  rd, C_OPC_RVX10);
            OP_MAX:  word = enc_r(C_F7_MINMAX, rs2, rs1, C_F3_MAX,  rd, C_OPC_RVX10);
            OP_MINU: word = enc_r(C_F7_MINMAX, rs2, rs1, C_F3_MINU, rd, C_OPC_RVX10);
            OP_MAXU: word = enc_r(C_F7_MINMAX, rs2, rs1, C_F3_MAXU, rd, C_OPC_RVX10);
            OP_ROL:  word = enc_r(C_F7_ROT,    rs2, rs1, C_F3_ROL,  rd, C_OPC_RVX10);
            OP_ROR:  word = enc_r(C_F7_ROT,    rs2, rs1, C_F3_ROR,  rd, C_OPC_RVX10);
            // ABS is unary: the rs2 slot is always encoded as zero
            OP_ABS:  word = enc_r(C_F7_ABS,    5'd0, rs1, C_F3_ABS, rd, C_OPC_RVX10);
            default: illegal = 1'b1;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/rvx10_encoder.sv
//------------------------------------------------------------------------------
// Module : rvx10_encoder
// Brief  : Streaming instruction encoder: request in, addressed word out, with
//          run/drain/error control and a written-word counter.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module rvx10_encoder
    import rvx10_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [31:0]       base_addr,
    input  logic              stop,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [4:0]        req_op,
    input  logic [4:0]        req_rd,
    input  logic [4:0]        req_rs1,
    input  logic [4:0]        req_rs2,
    input  logic [31:0]       req_imm,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic [31:0]       wr_addr,
    output logic [31:0]       wr_data,
    output logic              busy,
    output logic              err,
    output logic [CNT_W-1:0]  count
);

    state_t             state_q,    state_d;
    logic [31:0]        addr_q,     addr_d;
    logic [CNT_W-1:0]   count_q,    count_d;
    logic               err_q,      err_d;
    logic               wr_valid_q, wr_valid_d;
    logic [31:0]        wr_addr_q,  wr_addr_d;
    logic [31:0]        wr_data_q,  wr_data_d;

    logic [31:0]        w_enc_word;
    logic               w_enc_illegal;
    logic               w_accept;
    logic               w_hs;

    rvx10_encdec u_encdec (
        .op      (req_op),
        .rd      (req_rd),
        .rs1     (req_rs1),
        .rs2     (req_rs2),
        .imm     (req_imm),
        .word    (w_enc_word),
        .illegal (w_enc_illegal)
    );

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        count_d    = count_q;
        err_d      = err_q;
        wr_valid_d = wr_valid_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;

        req_ready = (state_q == ST_RUN) && !start && !stop && (!wr_valid_q || wr_ready);
        w_accept  = req_valid && req_ready;
        w_hs      = wr_valid_q && wr_ready;

        if (w_hs) begin
            wr_valid_d = 1'b0;
            count_d    = count_q + CNT_W'(1);
        end

        // start restarts from any state and discards a pending word
        if (start) begin
            state_d    = ST_RUN;
            addr_d     = base_addr;
            count_d    = '0;
            err_d      = 1'b0;
            wr_valid_d = 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (stop) begin
                        state_d = ST_DRAIN;
                    end else if (w_accept) begin
                        if (w_enc_illegal) begin
                            err_d   = 1'b1;
                            state_d = ST_ERR;
                        end else begin
                            wr_valid_d = 1'b1;
                            wr_addr_d  = addr_q;
                            wr_data_d  = w_enc_word;
                            addr_d     = addr_q + 32'd4;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (!wr_valid_q || w_hs) begin
                        state_d = ST_IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            addr_q     <= 32'd0;
            count_q    <= '0;
            err_q      <= 1'b0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= 32'd0;
            wr_data_q  <= 32'd0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            count_q    <= count_d;
            err_q      <= err_d;
            wr_valid_q <= wr_valid_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

    assign wr_valid = wr_valid_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign busy     = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign err      = err_q;
    assign count    = count_q;

endmodule

`default_nettype wire

// File: doc/rvx10_encoder.md
RVX10_ENCODER -- requirements
Module: rvx10_encoder

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the instruction counter.
REQ-002 SHALL have ports: clk input 1, rising-edge clock; reset input 1, asynchronous active-high reset.
REQ-003 SHALL have ports: start input 1 (pulse: arm, load base); base_addr input 32 (first word address); stop input 1 (pulse: finish after drain).
REQ-004 SHALL have request ports: req_valid input 1; req_ready output 1; req_op input 5 (enc_op_t); req_rd, req_rs1, req_rs2 input 5 each; req_imm input 32 (signed byte offset or immediate).
REQ-005 SHALL have write ports: wr_valid output 1; wr_ready input 1; wr_addr output 32; wr_data output 32 (encoded instruction).
REQ-006 SHALL have status ports: busy output 1 (state RUN or DRAIN); err output 1 (sticky); count output CNT_W (words written).

Function
REQ-007 SHALL implement FSM states IDLE, RUN, DRAIN, ERR; reset state IDLE.
REQ-008 IDLE/ERR/DRAIN: start -> RUN, addr counter <= base_addr, count <= 0, err <= 0; pending wr_valid word discarded.
REQ-009 RUN: stop -> DRAIN; DRAIN -> IDLE in the cycle wr_valid=0 or the final word handshakes.
REQ-010 req_ready SHALL be 1 only in RUN with start=0, stop=0, and (wr_valid=0 or wr_ready=1).
REQ-011 Accepted request (req_valid&req_ready) SHALL appear on wr_data/wr_addr with wr_valid=1 next cycle (latency 1, one output register, full throughput).
REQ-012 wr_valid, wr_addr, wr_data SHALL hold stable until wr_valid&wr_ready; on handshake wr_addr for the next word advances by 4 (wraps modulo 2^32), count increments (wraps modulo 2^CNT_W).
REQ-013 Encoding: R-type opcode 0110011 (ADD/SUB f3 000, f7 0000000/0100000; SLT 010; OR 110; AND 111); I-ALU 0010011 (ADDI 000, SLTI 010, ORI 110, ANDI 111); LW 0000011 f3 010; SW 0100011 f3 010; BEQ 1100011 f3 000; JAL 1101111.
REQ-014 RVX10 ops SHALL use opcode 0001011, R layout: f7 0000000 ANDN/ORN/XNOR f3 000/001/010; f7 0000001 MIN/MAX/MINU/MAXU f3 000/001/010/011; f7 0000010 ROL/ROR f3 000/001; f7 0000011 ABS f3 000 with rs2 field forced 0.
REQ-015 Immediates SHALL use RV32I I/S/B/J bit placement; unused register fields forced 0 (e.g. rs2 for I, rd for S/B).
REQ-016 Range errors: I/S imm outside [-2048,2047]; B imm outside [-4096,4094] or bit0=1; J imm outside [-2^20,2^20-2] or bit0=1.
REQ-017 Illegal req_op (23..31) or range error on an accepted request SHALL set err, produce no write, and move RUN -> ERR; any earlier wr_valid word still completes.
REQ-018 ERR: req_ready=0; exits only on start.
REQ-019 start in RUN SHALL restart (REQ-008) without accepting a request that cycle; start and stop together: start wins.

Reset
REQ-020 reset SHALL asynchronously force state IDLE, req_ready=0, wr_valid=0, wr_addr=0, wr_data=0, busy=0, err=0, count=0.
REQ-021 reset asserted mid-stream SHALL drop any pending word; no write handshake completes in a reset cycle.

Structure
REQ-022 enc_op_t enum (ADD=0,SUB,AND,OR,SLT,ADDI,ANDI,ORI,SLTI,LW,SW,BEQ,JAL,ANDN,ORN,XNOR,MIN,MAX,MINU,MAXU,ROL,ROR,ABS=22), opcode constants and RVX10 funct7/funct3 constants SHALL live in shared package rvx10_pkg.
REQ-023 Combinational encoding and range checking SHALL be a sub-module rvx10_encdec (op, fields, imm -> word, illegal); FSM, counters and output register in rvx10_encoder.

Verification
REQ-024 start base_addr=0x100, ANDN rd=5 rs1=6 rs2=7, wr_ready=1 -> next cycle wr_addr=0x100, wr_data=0x0073028B; count=1.
REQ-025 Back-to-back ABS rd=1 rs1=2 rs2=9, ADDI rd=1 rs1=0 imm=-1 -> words 0x0601008B @0x100, 0xFFF00093 @0x104, no bubbles.
REQ-026 BEQ rs1=0 rs2=0 imm=8 with wr_ready=0 for 3 cycles -> wr_data=0x00000463 held stable, req_ready=0, single write after wr_ready=1.
REQ-027 BEQ imm=3 -> err=1, state ERR, no write, req_ready=0; subsequent start clears err.
REQ-028 base_addr=0xFFFFFFFC, two ADDs -> addresses 0xFFFFFFFC then 0x00000000; stop with word pending -> DRAIN, busy=0 after handshake.
REQ-029 reset asserted while wr_valid=1 -> wr_valid=0 and count=0 immediately, no handshake.
